// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl
//   Launches two counting threads (A and B) together and signals the
//   downstream stage according to a join policy: wait for both (join), wait
//   for the first (join_any) or release right away (join_none). Threads that
//   outlive the join finish in DRAIN without producing another join_done.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             launch request, accepted only while idle
//   mode[1:0]         0 join, 1 join_any, 2 join_none, 3 join
//   dur_a, dur_b      thread durations in cycles (0 behaves as 1)
//   busy              high in RUN and DRAIN
//   a_active/b_active thread is still counting
//   a_done/b_done     one-cycle pulse at thread completion
//   join_done         one-cycle pulse when the join condition is met
//   start_drop        one-cycle pulse for a start seen while busy
module fork_join_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] dur_a,
    input  logic [CNT_W-1:0] dur_b,
    output logic             busy,
    output logic             a_active,
    output logic             b_active,
    output logic             a_done,
    output logic             b_done,
    output logic             join_done,
    output logic             start_drop
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    typedef enum logic [1:0] {J_ALL, J_ANY, J_NONE} join_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    join_t            join_reg, join_decoded;
    logic             launch;
    logic             join_now;
    logic             join_done_reg;
    logic             start_drop_reg;

    // Per-thread state, index 0 = A, index 1 = B.
    logic [CNT_W-1:0] dur_in [2];
    logic [CNT_W-1:0] cnt_reg [2];
    logic [1:0]       active_reg;
    logic [1:0]       done_reg;
    logic [1:0]       fin;      // thread completes at this edge
    logic [1:0]       rem;      // thread still active after this edge

    assign dur_in[0] = dur_a;
    assign dur_in[1] = dur_b;

    assign launch = (state_reg == S_IDLE) && start;

    always_comb begin
        case (mode)
            2'd1:    join_decoded = J_ANY;
            2'd2:    join_decoded = J_NONE;
            default: join_decoded = J_ALL;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_thread
            // A counter value of 1 means the thread finishes on this edge.
            assign fin[gi] = active_reg[gi] && (cnt_reg[gi] == CNT_ONE);
            assign rem[gi] = active_reg[gi] && !fin[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg[gi]    <= '0;
                    active_reg[gi] <= 1'b0;
                    done_reg[gi]   <= 1'b0;
                end else begin
                    done_reg[gi] <= 1'b0;
                    if (launch) begin
                        // Duration 0 is stretched to a single cycle.
                        cnt_reg[gi]    <= (dur_in[gi] == '0) ? CNT_ONE : dur_in[gi];
                        active_reg[gi] <= 1'b1;
                    end else if (fin[gi]) begin
                        active_reg[gi] <= 1'b0;
                        done_reg[gi]   <= 1'b1;
                    end else if (active_reg[gi]) begin
                        cnt_reg[gi] <= cnt_reg[gi] - CNT_ONE;
                    end
                end
            end
        end
    endgenerate

    // Join condition, evaluated only while the join is still pending (RUN).
    // join_none fires on the first RUN edge, i.e. one edge after launch.
    always_comb begin
        join_now = 1'b0;
        if (state_reg == S_RUN) begin
            case (join_reg)
                J_ANY:   join_now = |fin;
                J_NONE:  join_now = 1'b1;
                default: join_now = ~|rem;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (launch) state_next = S_RUN;
            end
            S_RUN: begin
                if (join_now) state_next = (|rem) ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (~|rem) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_reg != S_IDLE);
    end

    // Latched policy plus registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            join_reg       <= J_ALL;
            join_done_reg  <= 1'b0;
            start_drop_reg <= 1'b0;
        end else begin
            if (launch) join_reg <= join_decoded;
            join_done_reg  <= join_now;
            start_drop_reg <= start && (state_reg != S_IDLE);
        end
    end

    assign a_active   = active_reg[0];
    assign b_active   = active_reg[1];
    assign a_done     = done_reg[0];
    assign b_done     = done_reg[1];
    assign join_done  = join_done_reg;
    assign start_drop = start_drop_reg;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Directed bench for fork_join_ctrl. Edge numbers are counted from the
// launch edge (edge 0); outputs are sampled 1 time unit after each edge.
module tb_fork_join_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [7:0] dur_a, dur_b;
    logic       busy, a_active, b_active, a_done, b_done, join_done, start_drop;

    int checks = 0;
    int errors = 0;

    // Per-run observations
    int e;
    int a_edge, b_edge, j_edge, drop_edge, idle_edge;
    int a_cnt, b_cnt, j_cnt;
    int busy_at_join, a_act_at_done, b_act_at_done, busy_after;

    fork_join_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .dur_a(dur_a), .dur_b(dur_b),
        .busy(busy), .a_active(a_active), .b_active(b_active),
        .a_done(a_done), .b_done(b_done), .join_done(join_done),
        .start_drop(start_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [1:0] m, input logic [7:0] da, input logic [7:0] db);
        @(negedge clk);
        mode = m; dur_a = da; dur_b = db; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = 0;
    endtask

    task automatic sample();
        if (a_done) begin a_cnt++; if (a_edge < 0) begin a_edge = e; a_act_at_done = a_active; end end
        if (b_done) begin b_cnt++; if (b_edge < 0) begin b_edge = e; b_act_at_done = b_active; end end
        if (join_done) begin j_cnt++; if (j_edge < 0) begin j_edge = e; busy_at_join = busy; end end
        if (start_drop && drop_edge < 0) drop_edge = e;
        if (!busy && idle_edge < 0) idle_edge = e;
    endtask

    // Launch, scramble the inputs, optionally re-assert start so it is
    // sampled at edge drop_at, then follow until busy falls.
    task automatic run_op(input string name, input logic [1:0] m,
                          input logic [7:0] da, input logic [7:0] db, input int drop_at);
        a_edge = -1; b_edge = -1; j_edge = -1; drop_edge = -1; idle_edge = -1;
        a_cnt = 0; b_cnt = 0; j_cnt = 0;
        busy_at_join = -1; a_act_at_done = -1; b_act_at_done = -1;
        launch(m, da, db);
        check({name, ".busy0"}, busy, 1);
        check({name, ".act0"}, {30'd0, a_active, b_active}, 3);
        mode = ~m; dur_a = 8'd1; dur_b = 8'd1;   // must not disturb the run
        while (idle_edge < 0 && e < 400) begin
            if (e + 1 == drop_at) start = 1'b1;
            @(posedge clk); #1;
            e++;
            sample();
            if (e == drop_at) start = 1'b0;
        end
        if (idle_edge < 0) check({name, ".timeout"}, 0, 1);
        @(posedge clk); #1;
        e++;
        busy_after = busy;
        sample();
        $display("%s: mode=%0d da=%0d db=%0d a@%0d b@%0d join@%0d x%0d drop@%0d idle@%0d",
                 name, m, da, db, a_edge, b_edge, j_edge, j_cnt, drop_edge, idle_edge);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; dur_a = '0; dur_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.outs", {25'd0, a_active, b_active, a_done, b_done, join_done, start_drop}, 0);
        @(negedge clk); rst = 1'b0;

        // join: both threads, released by the later one
        run_op("join", 2'd0, 8'd20, 8'd30, -1);
        check("join.a", a_edge, 20); check("join.b", b_edge, 30);
        check("join.j", j_edge, 30); check("join.jn", j_cnt, 1);
        check("join.idle", idle_edge, 30); check("join.busyj", busy_at_join, 0);
        check("join.aact", a_act_at_done, 0);

        // join_any: released by A, B drains
        run_op("any", 2'd1, 8'd20, 8'd30, -1);
        check("any.a", a_edge, 20); check("any.j", j_edge, 20);
        check("any.drain", busy_at_join, 1); check("any.b", b_edge, 30);
        check("any.idle", idle_edge, 30); check("any.jn", j_cnt, 1);

        // join_any with simultaneous completion
        run_op("any_eq", 2'd1, 8'd5, 8'd5, -1);
        check("any_eq.a", a_edge, 5); check("any_eq.b", b_edge, 5);
        check("any_eq.j", j_edge, 5); check("any_eq.jn", j_cnt, 1);
        check("any_eq.idle", idle_edge, 5);

        // join_none with a zero-length thread
        run_op("none", 2'd2, 8'd3, 8'd0, -1);
        check("none.j", j_edge, 1); check("none.b", b_edge, 1);
        check("none.bact", b_act_at_done, 0); check("none.a", a_edge, 3);
        check("none.idle", idle_edge, 3); check("none.jn", j_cnt, 1);

        // start while busy is dropped and leaves the run alone
        run_op("drop", 2'd0, 8'd10, 8'd10, 4);
        check("drop.edge", drop_edge, 4); check("drop.a", a_edge, 10);
        check("drop.b", b_edge, 10); check("drop.j", j_edge, 10);
        check("drop.an", a_cnt, 1);

        // start on the very edge that returns to IDLE is dropped too
        run_op("drop_end", 2'd3, 8'd3, 8'd3, 3);
        check("drop_end.j", j_edge, 3); check("drop_end.edge", drop_edge, 3);
        check("drop_end.after", busy_after, 0);

        // maximum duration
        run_op("max", 2'd0, 8'd255, 8'd1, -1);
        check("max.a", a_edge, 255); check("max.b", b_edge, 1);
        check("max.j", j_edge, 255);

        // asynchronous reset mid-operation, then a fresh launch
        a_cnt = 0; b_cnt = 0; j_cnt = 0;
        launch(2'd1, 8'd8, 8'd8);
        repeat (4) begin @(posedge clk); #1; e++; end
        @(negedge clk); rst = 1'b1; #1;
        check("arst.busy", busy, 0);
        check("arst.act", {30'd0, a_active, b_active}, 0);
        @(posedge clk); #1;
        if (a_done) a_cnt++;
        if (b_done) b_cnt++;
        if (join_done) j_cnt++;
        check("arst.pulses", a_cnt + b_cnt + j_cnt, 0);
        check("arst.outs", {25'd0, busy, a_active, b_active, a_done, b_done, join_done, start_drop}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("arst.idle", busy, 0);
        run_op("after_rst", 2'd1, 8'd2, 8'd4, -1);
        check("after_rst.a", a_edge, 2); check("after_rst.j", j_edge, 2);
        check("after_rst.b", b_edge, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
